conv2d_stream_engine: RTL and testbench
=======================================

Name: conv2d_stream_engine

Overview:
- Streaming 3x3 2D convolution engine for raster-order 8-bit image frames. Next generation of the fixed Sobel engine.
- Parametrised frame size and data widths.
- Runtime-loadable signed kernel coefficients, output arithmetic shift, optional ReLU and saturation.
- Explicit drain phase, so done is raised only after the last result of the frame has been emitted.
- Sits between the pixel DMA/stream source and the feature-map writer in the NPU datapath.

Parameters:
- IMG_WIDTH, 32, pixels per row (min 3).
- IMG_HEIGHT, 32, rows per frame (min 3).
- PIX_W, 8, unsigned pixel width.
- COEF_W, 8, signed coefficient width.
- OUT_W, 16, signed saturated result width.
- SHIFT_W, 5, width of the output shift amount.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start_signal  in  1  begin frame; honoured only in IDLE
- busy  out  1  high in RUN or DRAIN
- coef_wr_en  in  1  coefficient write strobe
- coef_addr  in  4  coefficient index 0..8, row-major (row 0 = oldest line, col 0 = oldest pixel)
- coef_data  in  COEF_W  signed coefficient
- shift_amt  in  SHIFT_W  arithmetic right shift, sampled at start
- relu_en  in  1  clamp negatives to 0, sampled at start
- pixel_in  in  PIX_W  unsigned pixel
- pixel_valid  in  1  pixel qualifier; gaps allowed
- result_out  out  OUT_W  signed result
- result_valid  out  1  result qualifier
- done_signal  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; all counters, line buffers, window and pipeline registers = 0.
  - result_out = 0, result_valid = 0, done_signal = 0, busy = 0.
  - Coefficients restored to Sobel-X {1,0,-1, 2,0,-2, 1,0,-1}.
- Reset mid-frame aborts the frame; no partial done is raised.
- States:
  - IDLE -> RUN when start_signal. Clears cnt_x and cnt_y; latches shift_amt and relu_en.
  - RUN -> DRAIN on the accepted pixel at cnt_x = IMG_WIDTH-1, cnt_y = IMG_HEIGHT-1.
  - DRAIN: count 6 cycles, then -> DONE.
  - DONE: done_signal = 1 for this single cycle, then -> IDLE.
- start_signal outside IDLE is ignored.
- pixel_valid outside RUN is ignored: no buffer, window or counter update.
- Coefficient writes are accepted only in IDLE; writes in other states are dropped. Writes with coef_addr > 8 are ignored.
- Accepted pixel handling:
  - line_buf2[cnt_x] <= line_buf1[cnt_x]; line_buf1[cnt_x] <= pixel_in.
  - Window shifts one column left; new right column = {line_buf2[cnt_x], line_buf1[cnt_x], pixel_in}.
  - cnt_x wraps at IMG_WIDTH-1 and increments cnt_y.
- Window tag: valid when the pixel is accepted in RUN with cnt_x >= 2 and cnt_y >= 2. No padding, so each frame yields exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) results.
- Pipeline, latency = 6 clock edges from the edge that samples the pixel to result_valid high:
  - E0: window.
  - E1: 9 products, each PIX_W+COEF_W+1 bits signed; pixel is zero-extended.
  - E2..E5: adder tree 9->5->3->2->1. ACC_W = PIX_W+COEF_W+5, equal to 21 at defaults; no overflow is possible.
  - E6: post-process.
- The valid tag travels with data through the same pipeline and is independent of pixel_valid after capture. Gaps do not stall in-flight results.
- Post-process, in order:
  - arithmetic right shift by the latched shift_amt (floor);
  - ReLU if the latched relu_en;
  - saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- result_out holds its last value when result_valid = 0.
- The last result emits during DRAIN; done_signal fires the cycle after it. A start_signal in that DONE cycle is ignored; it is accepted in IDLE the following cycle.

Decomposition:
- Package conv_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - KERNEL_SIZE = 3 and PIPE_LAT = 6;
  - the default Sobel-X coefficient array;
  - the ACC_W function of PIX_W and COEF_W.
- Sub-module conv_line_buffer holds the two IMG_WIDTH-deep line buffers and the 3x3 window shift; it outputs the window array.
- The top level owns control, coefficients, the multiply and adder tree, and post-process.

Test Plan:
- 8x8 frame, default kernel, pixel = 4*x, shift 0, ReLU off -> 36 results, all -32. First result_valid exactly 6 cycles after accepting pixel (2,2); done_signal one pulse one cycle after the 36th result.
- Same frame with random 50% pixel_valid gaps -> identical 36 values; each result appears 6 cycles after its pixel.
- Coefs all 1, constant image 100, shift_amt 2 -> every result 225; all coefs -1 with relu_en 1 -> every result 0.
- Coefs all 127, all pixels 255, OUT_W 16 -> 291465 saturates to 32767; coefs all -128 with ReLU off -> -32768.
- coef_wr_en and start_signal pulsed during RUN -> both ignored; busy stays high, results unchanged, single done.
- rst low mid-frame at row 4 -> all outputs 0, default coefs restored. A subsequent full frame matches the first scenario exactly, with no stale line-buffer data.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the streaming 3x3 convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int KERNEL_SIZE = 3;
    localparam int NUM_TAPS    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PIPE_LAT    = 6;

    // Row-major, row 0 = oldest line, col 0 = oldest pixel.
    localparam int SOBEL_X [NUM_TAPS] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};

    // Nine products of (PIX_W+1)x(COEF_W) bits need 4 growth bits beyond the product width.
    function automatic int acc_w(input int pix_w, input int coef_w);
        return pix_w + coef_w + 5;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two raster line buffers plus the sliding 3x3 pixel window.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH = 32,
    parameter int PIX_W     = 8,
    parameter int XW        = $clog2(IMG_WIDTH)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          i_accept,
    input  logic [XW-1:0]                                 i_cnt_x,
    input  logic [PIX_W-1:0]                              i_pixel,
    output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIX_W-1:0] o_win
);

    logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];
    logic [PIX_W-1:0] r_lb2 [IMG_WIDTH];
    logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIX_W-1:0] r_win;
    logic [KERNEL_SIZE-1:0][PIX_W-1:0] w_col;

    // Index 0 is the oldest line, index 2 the incoming pixel.
    assign w_col = {i_pixel, r_lb1[i_cnt_x], r_lb2[i_cnt_x]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                r_lb1[i] <= '0;
                r_lb2[i] <= '0;
            end
            r_win <= '0;
        end else if (i_accept) begin
            r_lb2[i_cnt_x] <= r_lb1[i_cnt_x];
            r_lb1[i_cnt_x] <= i_pixel;
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE - 1; c++)
                    r_win[r][c] <= r_win[r][c+1];
                r_win[r][KERNEL_SIZE-1] <= w_col[r];
            end
        end
    end

    assign o_win = r_win;

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming 3x3 convolution: control FSM, coefficient bank, MAC tree and post-process.
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int PIX_W      = 8,
    parameter int COEF_W     = 8,
    parameter int OUT_W      = 16,
    parameter int SHIFT_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_signal,
    output logic               busy,
    input  logic               coef_wr_en,
    input  logic [3:0]         coef_addr,
    input  logic [COEF_W-1:0]  coef_data,
    input  logic [SHIFT_W-1:0] shift_amt,
    input  logic               relu_en,
    input  logic [PIX_W-1:0]   pixel_in,
    input  logic               pixel_valid,
    output logic [OUT_W-1:0]   result_out,
    output logic               result_valid,
    output logic               done_signal
);

    localparam int XW     = $clog2(IMG_WIDTH);
    localparam int YW     = $clog2(IMG_HEIGHT);
    localparam int DW     = $clog2(PIPE_LAT + 1);
    localparam int PROD_W = PIX_W + COEF_W + 1;
    localparam int ACC_W  = acc_w(PIX_W, COEF_W);
    localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    state_t               r_state;
    logic [XW-1:0]        r_cnt_x;
    logic [YW-1:0]        r_cnt_y;
    logic [DW-1:0]        r_drain;
    logic                 r_busy;
    logic                 r_done;
    logic [SHIFT_W-1:0]   r_shift;
    logic                 r_relu;
    logic signed [COEF_W-1:0] r_coef [NUM_TAPS];

    logic                 w_accept;
    logic                 w_tag;
    logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIX_W-1:0] w_win;

    logic signed [PROD_W-1:0] w_prod [NUM_TAPS];
    logic signed [PROD_W-1:0] r_prod [NUM_TAPS];
    logic signed [ACC_W-1:0]  r_s1 [5];
    logic signed [ACC_W-1:0]  r_s2 [3];
    logic signed [ACC_W-1:0]  r_s3 [2];
    logic signed [ACC_W-1:0]  r_sum;
    logic [PIPE_LAT:0]        r_vld_pipe;
    logic [OUT_W-1:0]         r_result;
    logic signed [EXT_W-1:0]  w_shifted;
    logic signed [EXT_W-1:0]  w_post;

    assign w_accept = (r_state == RUN) && pixel_valid;
    assign w_tag    = w_accept && (r_cnt_x >= XW'(2)) && (r_cnt_y >= YW'(2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt_x <= '0;
            r_cnt_y <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_shift <= '0;
            r_relu  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start_signal) begin
                    r_state <= RUN;
                    r_busy  <= 1'b1;
                    r_cnt_x <= '0;
                    r_cnt_y <= '0;
                    r_shift <= shift_amt;
                    r_relu  <= relu_en;
                end
                RUN: if (pixel_valid) begin
                    if (r_cnt_x == XW'(IMG_WIDTH - 1)) begin
                        r_cnt_x <= '0;
                        if (r_cnt_y == YW'(IMG_HEIGHT - 1)) begin
                            r_cnt_y <= '0;
                            r_drain <= '0;
                            r_state <= DRAIN;
                        end else begin
                            r_cnt_y <= r_cnt_y + 1'b1;
                        end
                    end else begin
                        r_cnt_x <= r_cnt_x + 1'b1;
                    end
                end
                // Hold until the final result has left the pipe so done trails it by one cycle.
                DRAIN: if (r_drain == DW'(PIPE_LAT)) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_drain <= r_drain + 1'b1;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_TAPS; k++)
                r_coef[k] <= COEF_W'(SOBEL_X[k]);
        end else if (coef_wr_en && (r_state == IDLE) && (coef_addr < 4'd9)) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    conv_line_buffer #(
        .IMG_WIDTH (IMG_WIDTH),
        .PIX_W     (PIX_W),
        .XW        (XW)
    ) u_line_buffer (
        .clk      (clk),
        .rst      (rst),
        .i_accept (w_accept),
        .i_cnt_x  (r_cnt_x),
        .i_pixel  (pixel_in),
        .o_win    (w_win)
    );

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        logic signed [PIX_W:0] w_pix;
        assign w_pix     = {1'b0, w_win[k / KERNEL_SIZE][k % KERNEL_SIZE]};
        assign w_prod[k] = PROD_W'(w_pix) * PROD_W'(r_coef[k]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_TAPS; k++) r_prod[k] <= '0;
            for (int i = 0; i < 5; i++) r_s1[i] <= '0;
            for (int i = 0; i < 3; i++) r_s2[i] <= '0;
            r_s3[0]    <= '0;
            r_s3[1]    <= '0;
            r_sum      <= '0;
            r_vld_pipe <= '0;
            r_result   <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[PIPE_LAT-1:0], w_tag};
            for (int k = 0; k < NUM_TAPS; k++) r_prod[k] <= w_prod[k];
            for (int i = 0; i < 4; i++)
                r_s1[i] <= ACC_W'(r_prod[2*i]) + ACC_W'(r_prod[2*i+1]);
            r_s1[4] <= ACC_W'(r_prod[8]);
            r_s2[0] <= r_s1[0] + r_s1[1];
            r_s2[1] <= r_s1[2] + r_s1[3];
            r_s2[2] <= r_s1[4];
            r_s3[0] <= r_s2[0] + r_s2[1];
            r_s3[1] <= r_s2[2];
            r_sum   <= r_s3[0] + r_s3[1];
            if (r_vld_pipe[PIPE_LAT-1])
                r_result <= w_post[OUT_W-1:0];
        end
    end

    // Floor shift, then ReLU, then saturate; widened so the clamp compare cannot wrap.
    always_comb begin
        w_shifted = EXT_W'(r_sum) >>> r_shift;
        w_post    = w_shifted;
        if (r_relu && w_post[EXT_W-1])
            w_post = '0;
        if (w_post > SAT_MAX)
            w_post = SAT_MAX;
        else if (w_post < SAT_MIN)
            w_post = SAT_MIN;
    end

    assign busy         = r_busy;
    assign done_signal  = r_done;
    assign result_valid = r_vld_pipe[PIPE_LAT];
    assign result_out   = r_result;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed + randomized bench for conv2d_stream_engine on an 8x8 frame.
module tb_conv2d_stream_engine;

    localparam int W = 8, H = 8, PIX_W = 8, COEF_W = 8, OUT_W = 16, SHIFT_W = 5;
    localparam int SOBEL [9] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_signal = 1'b0;
    logic               busy;
    logic               coef_wr_en = 1'b0;
    logic [3:0]         coef_addr = '0;
    logic [COEF_W-1:0]  coef_data = '0;
    logic [SHIFT_W-1:0] shift_amt = '0;
    logic               relu_en = 1'b0;
    logic [PIX_W-1:0]   pixel_in = '0;
    logic               pixel_valid = 1'b0;
    logic [OUT_W-1:0]   result_out;
    logic               result_valid;
    logic               done_signal;

    conv2d_stream_engine #(
        .IMG_WIDTH (W), .IMG_HEIGHT (H), .PIX_W (PIX_W),
        .COEF_W (COEF_W), .OUT_W (OUT_W), .SHIFT_W (SHIFT_W)
    ) dut (
        .clk (clk), .rst (rst), .start_signal (start_signal), .busy (busy),
        .coef_wr_en (coef_wr_en), .coef_addr (coef_addr), .coef_data (coef_data),
        .shift_amt (shift_amt), .relu_en (relu_en), .pixel_in (pixel_in),
        .pixel_valid (pixel_valid), .result_out (result_out),
        .result_valid (result_valid), .done_signal (done_signal)
    );

    always #5 clk = ~clk;

    typedef struct { longint v; int c; } exp_t;
    exp_t   q[$];
    int     n_cmp = 0, n_err = 0, cyc = 0;
    int     n_res, last_res_cyc, done_cnt, done_cyc;
    longint last_out = 0;
    int     mc [9];
    int     img [H][W];
    int     m_shift;
    bit     m_relu;

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Convolution straight from the frame array and the coefficient list.
    function automatic longint ref_px(input int x, input int y);
        longint s = 0;
        longint hi = (longint'(1) << (OUT_W - 1)) - 1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += longint'(mc[r*3+c]) * img[y-2+r][x-2+c];
        s = s >>> m_shift;
        if (m_relu && s < 0) s = 0;
        if (s > hi) s = hi;
        if (s < -hi - 1) s = -hi - 1;
        return s;
    endfunction

    task automatic step();
        exp_t e;
        @(posedge clk); #1;
        cyc++;
        if (result_valid) begin
            if (q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                e = q.pop_front();
                chk("result_value", $signed(result_out), e.v);
                chk("result_latency", cyc, e.c);
            end
            last_res_cyc = cyc;
            n_res++;
        end else begin
            chk("result_hold", $signed(result_out), last_out);
        end
        last_out = $signed(result_out);
        if (done_signal) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic write_coef(input int addr, input int data);
        coef_wr_en = 1'b1;
        coef_addr  = 4'(addr);
        coef_data  = COEF_W'(data);
        step();
        coef_wr_en = 1'b0;
        if (addr < 9) mc[addr] = data;
    endtask

    task automatic fill(input int mode, input int val);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = (mode == 0) ? 4 * x : (mode == 1) ? val : int'($urandom_range(0, 255));
    endtask

    task automatic run_frame(input int sh, input bit relu, input bit gaps, input bit inject,
                             input int abort_row);
        exp_t e;
        n_res = 0; done_cnt = 0; done_cyc = -1; last_res_cyc = -1;
        shift_amt = SHIFT_W'(sh); relu_en = relu; start_signal = 1'b1;
        step();
        start_signal = 1'b0;
        m_shift = sh; m_relu = relu;
        chk("busy_after_start", busy, 1);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (gaps) begin
                    while ($urandom_range(0, 1) == 1) begin
                        pixel_valid = 1'b0;
                        pixel_in = PIX_W'($urandom);
                        step();
                    end
                end
                if (inject && y == 3 && x == 1) begin
                    pixel_valid = 1'b0;
                    coef_wr_en = 1'b1; coef_addr = 4'd0; coef_data = 8'd50;
                    start_signal = 1'b1;
                    step();
                    coef_wr_en = 1'b0; start_signal = 1'b0;
                    chk("busy_during_run", busy, 1);
                end
                if (y == abort_row && x == 3) begin
                    rst = 1'b0;
                    #1;
                    chk("abort_result_out", $signed(result_out), 0);
                    chk("abort_result_valid", result_valid, 0);
                    chk("abort_done", done_signal, 0);
                    chk("abort_busy", busy, 0);
                    q.delete();
                    last_out = 0;
                    pixel_valid = 1'b0;
                    mc = SOBEL;
                    step();
                    step();
                    rst = 1'b1;
                    step();
                    chk("abort_no_done", done_cnt, 0);
                    return;
                end
                pixel_in = PIX_W'(img[y][x]);
                pixel_valid = 1'b1;
                step();
                if (x >= 2 && y >= 2) begin
                    e.v = ref_px(x, y);
                    e.c = cyc + 6;
                    q.push_back(e);
                end
            end
        end
        pixel_valid = 1'b0;
        for (int i = 0; i < 30 && done_cnt == 0; i++) step();
        chk("done_seen", done_cnt, 1);
        chk("busy_at_done", busy, 0);
        chk("result_count", n_res, (W - 2) * (H - 2));
        chk("done_after_last_result", done_cyc, last_res_cyc + 1);
        chk("queue_drained", q.size(), 0);
        repeat (3) step();
        chk("single_done", done_cnt, 1);
    endtask

    initial begin
        int v;
        mc = SOBEL;
        #2 rst = 1'b0;
        #2;
        chk("reset_result_out", $signed(result_out), 0);
        chk("reset_result_valid", result_valid, 0);
        chk("reset_done", done_signal, 0);
        chk("reset_busy", busy, 0);
        step();
        step();
        rst = 1'b1;
        step();

        fill(0, 0);
        run_frame(0, 0, 0, 0, -1);
        run_frame(0, 0, 1, 0, -1);

        for (int k = 0; k < 9; k++) write_coef(k, 1);
        fill(1, 100);
        run_frame(2, 0, 0, 0, -1);
        for (int k = 0; k < 9; k++) write_coef(k, -1);
        run_frame(0, 1, 0, 0, -1);

        for (int k = 0; k < 9; k++) write_coef(k, 127);
        fill(1, 255);
        run_frame(0, 0, 0, 0, -1);
        for (int k = 0; k < 9; k++) write_coef(k, -128);
        run_frame(0, 0, 0, 0, -1);

        for (int k = 0; k < 9; k++) begin
            v = int'($urandom_range(0, 255)) - 128;
            write_coef(k, v);
        end
        write_coef(9, 77);
        fill(2, 0);
        run_frame(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1, 1, -1);

        run_frame(3, 0, 0, 0, 4);
        fill(0, 0);
        run_frame(0, 0, 0, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
